// File: rtl/lfsr_step_ctrl_if.sv
// Command/response bundle for lfsr_step_ctrl.
//   cmd_*  : job request (seed, step budget, optional stop value) with valid/ready.
//   rsp_*  : job result (final count, steps taken, end reason) with valid/ready.
// The master modport belongs to the host/CSR agent; the slave modport belongs to the sequencer.
interface lfsr_step_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [WIDTH-1:0]  cmd_seed;
    logic [STEP_W-1:0] cmd_steps;
    logic              cmd_match_en;
    logic [WIDTH-1:0]  cmd_target;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_count;
    logic [STEP_W-1:0] rsp_steps;
    logic              rsp_hit;
    logic              rsp_aborted;

    modport master (
        output cmd_valid, cmd_seed, cmd_steps, cmd_match_en, cmd_target,
        input  cmd_ready,
        input  rsp_valid, rsp_count, rsp_steps, rsp_hit, rsp_aborted,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_seed, cmd_steps, cmd_match_en, cmd_target,
        output cmd_ready,
        output rsp_valid, rsp_count, rsp_steps, rsp_hit, rsp_aborted,
        input  rsp_ready
    );
endinterface

// File: rtl/lfsr_step_ctrl.sv
// lfsr_step_ctrl: command-driven sequencer for one count_load LFSR instance.
// A job loads a seed, then advances the LFSR until the step budget is spent,
// the (optional) target value is seen, or abort is raised. The final count,
// steps taken and end reason are returned on the response channel.
// Ports:
//   clk, rst_n   : clock (rising edge) and synchronous active-low reset
//   bus          : cmd/rsp valid-ready bundle (slave side)
//   abort        : terminates the job in LOAD or RUN; ignored elsewhere
//   lfsr_load_n  : to count_load.load_n (low only in LOAD)
//   lfsr_cen     : to count_load.cen (high only on RUN advance cycles)
//   lfsr_data    : to count_load.data (seed in LOAD, zero otherwise)
//   lfsr_count   : from count_load.count
module lfsr_step_ctrl #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    lfsr_step_ctrl_if.slave  bus,
    input  logic             abort,
    output logic             lfsr_load_n,
    output logic             lfsr_cen,
    output logic [WIDTH-1:0] lfsr_data,
    input  logic [WIDTH-1:0] lfsr_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  seed_q, seed_d;
    logic [WIDTH-1:0]  target_q, target_d;
    logic              match_en_q, match_en_d;
    logic [STEP_W-1:0] remaining_q, remaining_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [WIDTH-1:0]  rsp_count_q, rsp_count_d;
    logic [STEP_W-1:0] rsp_steps_q, rsp_steps_d;
    logic              rsp_hit_q, rsp_hit_d;
    logic              rsp_aborted_q, rsp_aborted_d;
    logic              run_adv;

    always_comb begin
        state_d       = state_q;
        seed_d        = seed_q;
        target_d      = target_q;
        match_en_d    = match_en_q;
        remaining_d   = remaining_q;
        steps_d       = steps_q;
        rsp_count_d   = rsp_count_q;
        rsp_steps_d   = rsp_steps_q;
        rsp_hit_d     = rsp_hit_q;
        rsp_aborted_d = rsp_aborted_q;
        run_adv       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    seed_d      = bus.cmd_seed;
                    target_d    = bus.cmd_target;
                    match_en_d  = bus.cmd_match_en;
                    remaining_d = bus.cmd_steps;
                    steps_d     = '0;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // An abort here reports whatever count_load held before the seed load.
                if (abort) begin
                    rsp_count_d   = lfsr_count;
                    rsp_steps_d   = '0;
                    rsp_hit_d     = 1'b0;
                    rsp_aborted_d = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // lfsr_count already reflects every advance issued so far, so the
                // match test on the first RUN cycle compares against the seed itself.
                if (abort || (match_en_q && (lfsr_count == target_q)) ||
                    (remaining_q == '0)) begin
                    rsp_count_d   = lfsr_count;
                    rsp_steps_d   = steps_q;
                    rsp_aborted_d = abort;
                    rsp_hit_d     = !abort && match_en_q && (lfsr_count == target_q);
                    state_d       = ST_DONE;
                end else begin
                    run_adv     = 1'b1;
                    remaining_d = remaining_q - STEP_W'(1);
                    steps_d     = steps_q + STEP_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rsp_count_q   <= '0;
            rsp_steps_q   <= '0;
            rsp_hit_q     <= 1'b0;
            rsp_aborted_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rsp_count_q   <= rsp_count_d;
            rsp_steps_q   <= rsp_steps_d;
            rsp_hit_q     <= rsp_hit_d;
            rsp_aborted_q <= rsp_aborted_d;
        end
    end

    // Job fields are always rewritten at acceptance before use, so they need no reset.
    always_ff @(posedge clk) begin
        seed_q      <= seed_d;
        target_q    <= target_d;
        match_en_q  <= match_en_d;
        remaining_q <= remaining_d;
        steps_q     <= steps_d;
    end

    // Strobes to count_load are gated by rst_n so nothing is loaded or advanced while in reset.
    assign bus.cmd_ready   = rst_n && (state_q == ST_IDLE);
    assign bus.rsp_valid   = (state_q == ST_DONE);
    assign bus.rsp_count   = rsp_count_q;
    assign bus.rsp_steps   = rsp_steps_q;
    assign bus.rsp_hit     = rsp_hit_q;
    assign bus.rsp_aborted = rsp_aborted_q;
    assign lfsr_load_n     = !(rst_n && (state_q == ST_LOAD));
    assign lfsr_cen        = rst_n && run_adv;
    assign lfsr_data       = (state_q == ST_LOAD) ? seed_q : '0;

endmodule
